untile_reduce_unit: RTL
=======================

// Module: untile_reduce_unit
// PURPOSE
// Inverse of the tile stage in the data_ops path. Takes a 256-element tile-expanded vector and folds
// each group of repeat_factor consecutive elements back into one element, giving a 64-element vector.
// Fold modes: pick-first (de-tile), saturating sum (gradient/accumulate), or signed max.
// Sits between the tile stage output (or the PE array) and the writeback buffer.
// Input and output use valid/ready handshakes.
// PARAMETERS
//   DATA_W   16   element width, signed two's complement
//   OUT_LEN  64   output elements
//   IN_LEN   256  input elements; must equal OUT_LEN*4
// PORTS
//   clk            in   1               clock; all state updates on rising edge
//   rst            in   1               reset, asynchronous, active-high
//   data_in        in   IN_LEN*DATA_W   flat input vector; element k = data_in[k*DATA_W +: DATA_W]
//   valid_in       in   1               input vector valid
//   ready_in       out  1               unit can accept a vector
//   repeat_factor  in   4               group size; sampled on accept
//   reduce_mode    in   2               0 pick-first, 1 sat-sum, 2 max, 3 = pick-first; sampled on accept
//   data_out       out  OUT_LEN*DATA_W  flat output vector; element i = data_out[i*DATA_W +: DATA_W]
//   valid_out      out  1               output vector valid
//   ready_out      in   1               downstream accepts output
//   busy           out  1               high in any state other than IDLE
// BEHAVIOUR
// - Reset (async, active-high): state=IDLE, valid_out=0, data_out=0, accumulators=0, busy=0.
//   ready_in=1 while rst is high and after it deasserts. Reset mid-REDUCE or mid-OUTPUT aborts the
//   vector silently; nothing is emitted.
// - States:
//   - IDLE: ready_in=1 (ready_in is combinational, = state==IDLE).
//     - Accept on valid_in & ready_in. Capture data_in into an internal buffer, latch the effective
//       factor rf and the mode, clear counter j, go to REDUCE.
//     - Upstream may change data_in after acceptance.
//   - REDUCE: one fold step per cycle for all i in 0..OUT_LEN-1, in parallel.
//     - Step j: src = buf[i*rf+j].
//     - j=0: acc[i]=sign-extended src.
//     - j>0: pick-first leaves acc unchanged; sum does acc+=src; max does acc=max(acc,src), signed.
//     - On the step where j==rf-1: load data_out from acc, set valid_out=1, go to OUTPUT.
//   - OUTPUT: data_out and valid_out held stable until ready_out=1.
//     - On the ready_out edge: valid_out<=0, go to IDLE. Next accept is possible one cycle later.
//     - No same-cycle output-then-input bypass.
// - Effective factor rf:
//   - repeat_factor 0 -> 1; values >4 -> 4 (IN_LEN/OUT_LEN); 1..4 used as-is.
//   - rf=1 passes elements 0..63 through. In general input elements at index >= OUT_LEN*rf are ignored.
// - Latency: acceptance edge E0. valid_out is high after edge E_rf, i.e. rf cycles after accept.
// - Arithmetic:
//   - acc is DATA_W+2 bits, signed.
//   - Sum result is saturated to [-32768, 32767] only when loaded into data_out. No intermediate
//     saturation.
//   - Max and pick-first results always fit in DATA_W bits and are truncated losslessly.
// - Mode value 3 behaves exactly as 0.
// - valid_in while busy is ignored (ready_in=0). The vector is not captured.
// TESTING
// 1. Reset then idle: rst=1 mid-REDUCE -> valid_out=0, data_out=0, ready_in=1, busy=0 immediately;
//    no output after release.
// 2. Pick-first, rf=4: in[k]=k -> out[i]=4*i (out[63]=252). valid_out rises 4 cycles after accept.
// 3. Sum, rf=2: in[k]=k-128 -> out[i]=(2i-128)+(2i-127)=4i-255 (out[0]=-255, out[63]=-3).
//    Latency 2.
// 4. Sum saturation, rf=4, all inputs 16'h7000 -> every out=32767.
//    Mixed groups {32767,32767,-32768,-32768} -> -2 (no intermediate clamp).
// 5. Max, rf=3, group {-5,7,-9} at each i -> out=7.
//    repeat_factor=9 clamps to 4; repeat_factor=0 acts as 1 (out[i]=in[i]).
// 6. Backpressure: ready_out=0 for 10 cycles -> data_out/valid_out stable, ready_in=0, a new
//    valid_in is ignored. ready_out=1 -> valid_out drops next edge, ready_in=1.

Source files
------------

// File: rtl/untile_reduce_unit.sv
// rtl/untile_reduce_unit.sv - fold a tile-expanded vector back to one element per group
//
// Purpose:
//   Inverse of the tile stage. A 256-element input vector is treated as 64 groups
//   of rf consecutive elements (rf = effective repeat factor, 1..4). Each group is
//   folded into a single output element by pick-first, saturating sum or signed max.
//   All 64 lanes fold in parallel, one group member per cycle, so a vector takes rf
//   cycles from accept to valid_out.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   data_in        flat input vector, element k = data_in[k*DATA_W +: DATA_W]
//   valid_in       input vector valid
//   ready_in       unit idle and able to accept (combinational, state == IDLE)
//   repeat_factor  group size, 0 -> 1, >4 -> 4; sampled on accept
//   reduce_mode    0/3 pick-first, 1 saturating sum, 2 signed max; sampled on accept
//   data_out       flat output vector, element i = data_out[i*DATA_W +: DATA_W]
//   valid_out      output vector valid, held until ready_out
//   ready_out      downstream accepts the output vector
//   busy           high whenever the unit is not idle

module untile_reduce_unit #(
  parameter int DATA_W  = 16,
  parameter int OUT_LEN = 64,
  parameter int IN_LEN  = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_LEN*DATA_W-1:0]    data_in,
  input  logic                        valid_in,
  output logic                        ready_in,
  input  logic [3:0]                  repeat_factor,
  input  logic [1:0]                  reduce_mode,
  output logic [OUT_LEN*DATA_W-1:0]   data_out,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic                        busy
);

  localparam int ACC_W  = DATA_W + 2;
  localparam int MAX_RF = IN_LEN / OUT_LEN;
  localparam int IDX_W  = $clog2(IN_LEN);

  localparam logic [1:0] MODE_SUM = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;

  // Saturation bounds of a DATA_W signed value, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                      state_q;
  logic [2:0]                  j_q;
  logic [2:0]                  rf_q;
  logic [1:0]                  mode_q;
  logic [OUT_LEN*ACC_W-1:0]    acc_q;
  logic [DATA_W-1:0]           vec_buf [IN_LEN];

  logic [2:0]                  rf_eff;
  logic [OUT_LEN*ACC_W-1:0]    acc_next;
  logic [OUT_LEN*DATA_W-1:0]   out_next;
  logic                        accept;

  assign ready_in = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign accept   = valid_in && ready_in;

  // Clamp the requested factor into 1..MAX_RF.
  always_comb begin
    rf_eff = 3'd1;
    if (repeat_factor == 4'd0) begin
      rf_eff = 3'd1;
    end else if (repeat_factor > 4'(MAX_RF)) begin
      rf_eff = 3'(MAX_RF);
    end else begin
      rf_eff = repeat_factor[2:0];
    end
  end

  // Input snapshot; upstream is free to change data_in after the accept edge.
  // No reset: contents are only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < IN_LEN; k++) begin
        vec_buf[k] <= data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  // Per-lane fold step and output formatting.
  for (genvar g = 0; g < OUT_LEN; g++) begin : g_lane
    logic [IDX_W-1:0]          idx;
    logic signed [DATA_W-1:0]  src;
    logic signed [ACC_W-1:0]   src_ext;
    logic signed [ACC_W-1:0]   acc_cur;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic [DATA_W-1:0]         res;

    assign idx     = IDX_W'(g) * IDX_W'(rf_q) + IDX_W'(j_q);
    assign src     = vec_buf[idx];
    assign src_ext = {{(ACC_W-DATA_W){src[DATA_W-1]}}, src};
    assign acc_cur = acc_q[g*ACC_W +: ACC_W];

    always_comb begin
      acc_nxt = acc_cur;
      if (j_q == 3'd0) begin
        acc_nxt = src_ext;
      end else begin
        case (mode_q)
          MODE_SUM: acc_nxt = acc_cur + src_ext;
          MODE_MAX: if (src_ext > acc_cur) acc_nxt = src_ext;
          default:  acc_nxt = acc_cur;
        endcase
      end
    end

    // Only a sum can leave the DATA_W range; for the other modes the clamp is a no-op.
    always_comb begin
      res = acc_nxt[DATA_W-1:0];
      if (acc_nxt > SAT_MAX) begin
        res = SAT_MAX[DATA_W-1:0];
      end else if (acc_nxt < SAT_MIN) begin
        res = SAT_MIN[DATA_W-1:0];
      end
    end

    assign acc_next[g*ACC_W +: ACC_W]   = acc_nxt;
    assign out_next[g*DATA_W +: DATA_W] = res;
  end

  // Control FSM with registered outputs. The last fold step loads data_out from the
  // freshly computed accumulator so valid_out rises exactly rf cycles after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      j_q       <= 3'd0;
      rf_q      <= 3'd1;
      mode_q    <= 2'd0;
      acc_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            rf_q    <= rf_eff;
            mode_q  <= reduce_mode;
            j_q     <= 3'd0;
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          acc_q <= acc_next;
          j_q   <= j_q + 3'd1;
          if (j_q == rf_q - 3'd1) begin
            data_out  <= out_next;
            valid_out <= 1'b1;
            state_q   <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (ready_out) begin
            valid_out <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
